// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} fetch_state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: async reset to RESET_PC, word-aligned load, +4 increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] target_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  // Load wins over increment so a redirect always beats the sequential step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= {target_i[31:2], 2'b00};
    end else if (inc_i) begin
      pc_q <= pc_q + PC_INC;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: one outstanding imem read, redirect handling, and a single-entry output to decode.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        IReqValid,
  output logic [31:0] IReqAddr,
  input  logic        IReqReady,
  input  logic        IRspValid,
  input  logic [31:0] IRspData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  output logic [31:0] PC
);

  fetch_state_t state_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         instr_valid_q;
  logic [31:0]  pc;
  logic         pc_inc;

  // A redirect reloads the PC in every state; only a clean response advances it.
  assign pc_inc = (state_q == WAIT) && IRspValid && !Redirect;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load_i   (Redirect),
    .target_i (RedirectTarget),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= REQ;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        REQ: begin
          if (Redirect) begin
            // An already-accepted request now targets a stale PC and must be drained.
            state_q <= IReqReady ? DROP : REQ;
          end else if (IReqReady) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (Redirect) begin
            state_q <= IRspValid ? REQ : DROP;
          end else if (IRspValid) begin
            instr_q       <= IRspData;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        DROP: begin
          if (IRspValid) begin
            state_q <= REQ;
          end
        end
        HOLD: begin
          if (Redirect || InstrReady) begin
            instr_valid_q <= 1'b0;
            state_q       <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  assign IReqValid  = (state_q == REQ) && !reset;
  assign IReqAddr   = pc;
  assign PC         = pc;
  assign InstrValid = instr_valid_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: table-driven sequential fetches with a scoreboard, plus redirect/reset sequences.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_W = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        IReqReady;
  logic        IRspValid;
  logic [31:0] IRspData;
  logic        InstrReady;

  logic        IReqValid, InstrValid;
  logic [31:0] IReqAddr, Instr, InstrPC, PC;
  logic        w_IReqValid, w_InstrValid;
  logic [31:0] w_IReqAddr, w_Instr, w_InstrPC, w_PC;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(IReqReady),
    .IRspValid(IRspValid), .IRspData(IRspData), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .InstrReady(InstrReady), .PC(PC)
  );

  pc_fetch_unit #(.RESET_PC(RESET_W)) dut_w (
    .clk(clk), .reset(reset), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .IReqValid(w_IReqValid), .IReqAddr(w_IReqAddr), .IReqReady(IReqReady),
    .IRspValid(IRspValid), .IRspData(IRspData), .InstrValid(w_InstrValid),
    .Instr(w_Instr), .InstrPC(w_InstrPC), .InstrReady(InstrReady), .PC(w_PC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_w;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          req_stall;
    int          hold_stall;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] w_off;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic fetch_to_hold(input logic [31:0] addr, input int lat, input int req_stall);
    chk("req_valid", {31'd0, IReqValid}, 32'd1);
    chk("req_addr", IReqAddr, addr);
    chk("w_req_addr", w_IReqAddr, addr + w_off);
    repeat (req_stall) begin
      IReqReady = 1'b0;
      cyc();
      chk("req_valid_stalled", {31'd0, IReqValid}, 32'd1);
    end
    IReqReady = 1'b1;
    cyc();
    IReqReady = 1'b0;
    sb.push_back('{addr, addr + w_off, word_of(addr)});
    chk("req_idle_in_wait", {31'd0, IReqValid}, 32'd0);
    repeat (lat - 1) begin
      cyc();
      chk("no_instr_in_wait", {31'd0, InstrValid}, 32'd0);
    end
    IRspValid = 1'b1;
    IRspData  = word_of(addr);
    cyc();
    IRspValid = 1'b0;
    IRspData  = '0;
    chk("instr_valid", {31'd0, InstrValid}, 32'd1);
    chk("pc_inc", PC, addr + 32'd4);
  endtask

  task automatic consume(input int hold_stall);
    exp_t e;
    repeat (hold_stall) begin
      InstrReady = 1'b0;
      cyc();
      chk("hold_valid", {31'd0, InstrValid}, 32'd1);
      chk("hold_no_req", {31'd0, IReqValid}, 32'd0);
      if (sb.size() > 0) chk("hold_instr_stable", Instr, sb[0].word);
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("instr", Instr, e.word);
      chk("instr_pc", InstrPC, e.pc);
      chk("w_instr_pc", w_InstrPC, e.pc_w);
    end
    InstrReady = 1'b1;
    cyc();
    InstrReady = 1'b0;
    chk("consumed", {31'd0, InstrValid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    exp_t e;
    vecs[0] = '{32'h0000_0000, 1, 0, 0};
    vecs[1] = '{32'h0000_0004, 1, 0, 0};
    vecs[2] = '{32'h0000_0008, 1, 0, 0};
    vecs[3] = '{32'h0000_000C, 1, 0, 5};
    vecs[4] = '{32'h0000_0010, 3, 2, 0};
    vecs[5] = '{32'h0000_0014, 2, 0, 1};

    reset = 1'b1; Redirect = 1'b0; RedirectTarget = '0; IReqReady = 1'b0;
    IRspValid = 1'b0; IRspData = '0; InstrReady = 1'b0;
    w_off = RESET_W;
    cyc(); cyc();
    chk("rst_req_valid", {31'd0, IReqValid}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_w_pc", w_PC, RESET_W);
    chk("rst_instr_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_instr_pc", InstrPC, 32'h0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      fetch_to_hold(vecs[i].addr, vecs[i].lat, vecs[i].req_stall);
      consume(vecs[i].hold_stall);
    end

    // unsolicited response in REQ is ignored
    IRspValid = 1'b1; IRspData = 32'h1111_2222;
    cyc();
    IRspValid = 1'b0;
    chk("unsol_req_valid", {31'd0, IReqValid}, 32'd1);
    chk("unsol_no_instr", {31'd0, InstrValid}, 32'd0);

    // redirect in WAIT, stale response 3 cycles later
    chk("wait_req_addr", IReqAddr, 32'h0000_0018);
    IReqReady = 1'b1;
    cyc();
    IReqReady = 1'b0;
    Redirect = 1'b1; RedirectTarget = 32'h0000_1003;
    cyc();
    Redirect = 1'b0;
    chk("wait_redir_pc", PC, 32'h0000_1000);
    chk("wait_redir_no_req", {31'd0, IReqValid}, 32'd0);
    repeat (2) begin
      cyc();
      chk("drop_no_instr", {31'd0, InstrValid}, 32'd0);
    end
    IRspValid = 1'b1; IRspData = 32'hBAD0_BAD0;
    cyc();
    IRspValid = 1'b0;
    chk("drop_no_stale", {31'd0, InstrValid}, 32'd0);
    w_off = 32'h0;
    fetch_to_hold(32'h0000_1000, 1, 0);
    consume(0);

    // redirect together with acceptance in REQ
    IReqReady = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h0000_2000;
    cyc();
    IReqReady = 1'b0; Redirect = 1'b0;
    chk("req_redir_no_req", {31'd0, IReqValid}, 32'd0);
    chk("req_redir_pc", PC, 32'h0000_2000);
    cyc();
    chk("drop_holds", {31'd0, IReqValid}, 32'd0);
    IRspValid = 1'b1; IRspData = 32'hBAD1_BAD1;
    cyc();
    IRspValid = 1'b0;
    chk("drop_exit_no_instr", {31'd0, InstrValid}, 32'd0);
    fetch_to_hold(32'h0000_2000, 1, 0);
    consume(0);

    // redirect in REQ without acceptance changes the address in place
    Redirect = 1'b1; RedirectTarget = 32'h0000_3001;
    cyc();
    Redirect = 1'b0;
    fetch_to_hold(32'h0000_3000, 1, 0);

    // redirect in HOLD together with InstrReady: instruction delivered, fetch goes to target
    e = sb.pop_front();
    chk("hold_redir_instr", Instr, e.word);
    chk("hold_redir_instr_pc", InstrPC, e.pc);
    InstrReady = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h0000_4000;
    cyc();
    InstrReady = 1'b0; Redirect = 1'b0;
    chk("hold_redir_valid", {31'd0, InstrValid}, 32'd0);

    // reset asserted while in HOLD
    fetch_to_hold(32'h0000_4000, 1, 0);
    e = sb.pop_front();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_w_pc", w_PC, RESET_W);
    chk("async_rst_req", {31'd0, IReqValid}, 32'd0);
    cyc();
    reset = 1'b0;
    w_off = RESET_W;
    cyc();
    fetch_to_hold(32'h0000_0000, 1, 0);
    consume(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
